// File: rtl/ldpc_enc.sv
// Sequential QC-LDPC encoder for dual-diagonal block-circulant parity-check matrices.
// Accumulates per-row message syndromes (lambda), then solves the parity chain one block per cycle.
module ldpc_enc #(
  parameter int mtx_w = 8,
  parameter int R     = 24,
  parameter int C     = 12,
  parameter int D     = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [(R-C)*D-1:0]       msg,
  input  logic [C*R*mtx_w-1:0]     mtx,
  output logic                     busy,
  output logic                     valid,
  output logic [R*D-1:0]           cw
);

  localparam int K  = R - C;
  localparam int RW = (C > 1) ? $clog2(C) : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, LAMB, PAR} state_t;

  state_t               state, state_nxt;
  logic [K*D-1:0]       mreg;
  logic [D-1:0]         mblk [K];
  logic [mtx_w-1:0]     smsg [C][K];
  logic [mtx_w-1:0]     spar [C];
  logic [D-1:0]         lam  [C];
  logic [D-1:0]         p0acc, pacc;
  logic [(C-2)*D-1:0]   par_sr, par_shift;
  logic [RW-1:0]        r;
  logic [CW-1:0]        c;
  logic                 last_c, last_r, last_i;
  logic [D-1:0]         lam_nxt, pacc_nxt;
  logic [C*(C-1)*mtx_w-1:0] unused_dd;

  // y = P^s x : y[k] = x[(k+s) mod D]; any s >= D is the null block.
  function automatic logic [D-1:0] rot(input logic [D-1:0] x, input logic [mtx_w-1:0] s);
    if (int'(s) >= D) return '0;
    return D'({x, x} >> s);
  endfunction

  for (genvar gi = 0; gi < C; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_msg
      assign smsg[gi][gj] = mtx[(gi*R+gj)*mtx_w +: mtx_w];
    end
    assign spar[gi] = mtx[(gi*R+K)*mtx_w +: mtx_w];
    // Dual-diagonal columns are identity by construction and never consulted.
    for (genvar gj = K + 1; gj < R; gj++) begin : g_dd
      assign unused_dd[(gi*(C-1)+gj-K-1)*mtx_w +: mtx_w] = mtx[(gi*R+gj)*mtx_w +: mtx_w];
    end
  end

  for (genvar gj = 0; gj < K; gj++) begin : g_mblk
    assign mblk[gj] = mreg[gj*D +: D];
  end

  // Parity blocks p1..p_{C-2} collect here; p_{C-1} goes straight into cw.
  if (C > 3) begin : g_sr_long
    assign par_shift = {pacc_nxt, par_sr[(C-2)*D-1:D]};
  end else begin : g_sr_short
    assign par_shift = pacc_nxt;
  end

  assign busy = (state != IDLE);

  always_comb begin
    last_c   = (c == CW'(K - 1));
    last_r   = (r == RW'(C - 1));
    last_i   = (r == RW'(C - 2));
    lam_nxt  = lam[r] ^ rot(mblk[c], smsg[r][c]);
    pacc_nxt = pacc ^ lam[r] ^ rot(p0acc, spar[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)           state_nxt = LAMB;
      LAMB:    if (last_r && last_c) state_nxt = PAR;
      PAR:     if (last_i)          state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mreg   <= '0;
      p0acc  <= '0;
      pacc   <= '0;
      par_sr <= '0;
      r      <= '0;
      c      <= '0;
      cw     <= '0;
      valid  <= 1'b0;
      for (int k = 0; k < C; k++) lam[k] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mreg   <= msg;
          p0acc  <= '0;
          pacc   <= '0;
          par_sr <= '0;
          r      <= '0;
          c      <= '0;
          for (int k = 0; k < C; k++) lam[k] <= '0;
        end
        // lambda phase: row r, message column c; p0 is the XOR of finished lambdas
        LAMB: begin
          lam[r] <= lam_nxt;
          if (last_c) begin
            p0acc <= p0acc ^ lam_nxt;
            c     <= '0;
            r     <= last_r ? '0 : r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        // parity chain: p_{i+1} = p_i ^ lambda_i ^ P^s(i,K) p0
        PAR: begin
          pacc   <= pacc_nxt;
          par_sr <= par_shift;
          r      <= r + 1'b1;
          if (last_i) begin
            cw    <= {pacc_nxt, par_sr, p0acc, mreg};
            valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_enc.sv
// Directed bench for ldpc_enc: a default-size instance checked by timing and syndrome,
// and a small R=5/C=3/D=4 instance checked against hand-computed codewords.
module tb_ldpc_enc;

  localparam int DR = 24, DC = 12, DD = 96, DW = 8, DK = DR - DC;
  localparam int SR = 5,  SC = 3,  SD = 4,  SW = 3, SK = SR - SC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    start_d = 1'b0;
  logic [DK*DD-1:0]        msg_d = '0;
  logic [DC*DR*DW-1:0]     mtx_d = '0;
  logic                    busy_d, valid_d;
  logic [DR*DD-1:0]        cw_d;

  logic                    start_s = 1'b0;
  logic [SK*SD-1:0]        msg_s = '0;
  logic [SC*SR*SW-1:0]     mtx_s = '0;
  logic                    busy_s, valid_s;
  logic [SR*SD-1:0]        cw_s;

  int n_vec = 0;
  int n_err = 0;

  ldpc_enc #(.mtx_w(DW), .R(DR), .C(DC), .D(DD)) u_dut (
    .clk(clk), .rst(rst), .start(start_d), .msg(msg_d), .mtx(mtx_d),
    .busy(busy_d), .valid(valid_d), .cw(cw_d)
  );

  ldpc_enc #(.mtx_w(SW), .R(SR), .C(SC), .D(SD)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .msg(msg_s), .mtx(mtx_s),
    .busy(busy_s), .valid(valid_s), .cw(cw_s)
  );

  function automatic logic [DD-1:0] brot(input logic [DD-1:0] x, input int s);
    logic [DD-1:0] y;
    y = '0;
    if (s >= DD) return y;
    for (int k = 0; k < DD; k++) y[k] = x[(k + s) % DD];
    return y;
  endfunction

  // Number of check rows of the default matrix that the word violates.
  function automatic int bad_rows(input logic [DR*DD-1:0] w);
    int n;
    logic [DD-1:0] acc;
    n = 0;
    for (int i = 0; i < DC; i++) begin
      acc = '0;
      for (int j = 0; j < DR; j++)
        acc ^= brot(w[j*DD +: DD], int'(mtx_d[(i*DR+j)*DW +: DW]));
      if (acc != '0) n++;
    end
    return n;
  endfunction

  function automatic logic [DK*DD-1:0] rnd_msg();
    logic [DK*DD-1:0] m;
    for (int k = 0; k < DK*DD/32; k++) m[k*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_d(input logic [DK*DD-1:0] m);
    msg_d   = m;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
  endtask

  task automatic go_s(input logic [SK*SD-1:0] m);
    msg_s   = m;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic wait_d(output int lat);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (valid_d) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic wait_s(output int lat);
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (valid_s) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic set_small(input int s00);
    int tbl [3][5] = '{'{0, 3, 1, 0, 7}, '{7, 1, 0, 0, 0}, '{2, 7, 1, 7, 0}};
    tbl[0][0] = s00;
    for (int i = 0; i < SC; i++)
      for (int j = 0; j < SR; j++)
        mtx_s[(i*SR+j)*SW +: SW] = SW'(tbl[i][j]);
  endtask

  task automatic set_default();
    int s;
    for (int i = 0; i < DC; i++)
      for (int j = 0; j < DR; j++) begin
        if (j < DK)       s = ((i + j) % 5 == 0) ? 255 : (i*37 + j*11) % DD;
        else if (j == DK) s = (i == 0 || i == DC-1) ? 3 : (i == 5) ? 0 : 255;
        else              s = (i == j-DK-1 || i == j-DK) ? 0 : 255;
        mtx_d[(i*DR+j)*DW +: DW] = DW'(s);
      end
    mtx_d[(1*DR+1)*DW +: DW] = DW'(DD - 1);
    mtx_d[(2*DR+3)*DW +: DW] = DW'(0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if (busy_d !== 1'b0)   begin n_err++; $display("FAIL rst_busy_d: got %b want 0", busy_d); end
    n_vec++; if (valid_d !== 1'b0)  begin n_err++; $display("FAIL rst_valid_d: got %b want 0", valid_d); end
    n_vec++; if (cw_d !== '0)       begin n_err++; $display("FAIL rst_cw_d: got %0h want 0", cw_d); end
    n_vec++; if (busy_s !== 1'b0)   begin n_err++; $display("FAIL rst_busy_s: got %b want 0", busy_s); end
    n_vec++; if (valid_s !== 1'b0)  begin n_err++; $display("FAIL rst_valid_s: got %b want 0", valid_s); end
    n_vec++; if (cw_s !== '0)       begin n_err++; $display("FAIL rst_cw_s: got %0h want 0", cw_s); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat;
    go_d('0);
    n_vec++; if (busy_d !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b want 1", busy_d); end
    wait_d(lat);
    n_vec++; if (lat !== 155)     begin n_err++; $display("FAIL zero_latency: got %0d want 155", lat); end
    n_vec++; if (cw_d !== '0)     begin n_err++; $display("FAIL zero_cw: got %0h want 0", cw_d); end
    n_vec++; if (busy_d !== 1'b0) begin n_err++; $display("FAIL zero_busy_end: got %b want 0", busy_d); end
  endtask

  task automatic test_small();
    logic [7:0]  sm [3] = '{8'h01, 8'h10, 8'h11};
    logic [19:0] se [3] = '{20'hEB501, 20'h57A10, 20'hBCF11};
    int lat;
    set_small(0);
    for (int v = 0; v < 3; v++) begin
      go_s(sm[v]);
      wait_s(lat);
      n_vec++; if (lat !== 8)      begin n_err++; $display("FAIL small_lat[%0d]: got %0d want 8", v, lat); end
      n_vec++; if (cw_s !== se[v]) begin n_err++; $display("FAIL small_cw[%0d]: got %0h want %0h", v, cw_s, se[v]); end
    end
    set_small(3);
    go_s(8'h08);
    wait_s(lat);
    n_vec++; if (lat !== 8)          begin n_err++; $display("FAIL small_lat_d1: got %0d want 8", lat); end
    n_vec++; if (cw_s !== 20'hB8308) begin n_err++; $display("FAIL small_cw_d1: got %0h want b8308", cw_s); end
    tick();
    n_vec++; if (valid_s !== 1'b0)   begin n_err++; $display("FAIL small_pulse: got %b want 0", valid_s); end
    n_vec++; if (cw_s !== 20'hB8308) begin n_err++; $display("FAIL small_hold: got %0h want b8308", cw_s); end
  endtask

  task automatic test_code();
    logic [DK*DD-1:0] m;
    int lat, nb;
    for (int v = 0; v < 5; v++) begin
      m = '0;
      if (v == 0)      m[0] = 1'b1;
      else if (v == 1) m[5*DD + DD-1] = 1'b1;
      else             m = rnd_msg();
      go_d(m);
      wait_d(lat);
      nb = bad_rows(cw_d);
      n_vec++; if (lat !== 155)             begin n_err++; $display("FAIL code_lat[%0d]: got %0d want 155", v, lat); end
      n_vec++; if (cw_d[DK*DD-1:0] !== m)   begin n_err++; $display("FAIL code_sys[%0d]: got %0h want %0h", v, cw_d[DK*DD-1:0], m); end
      n_vec++; if (nb !== 0)                begin n_err++; $display("FAIL code_syndrome[%0d]: got %0d bad rows want 0", v, nb); end
    end
  endtask

  task automatic test_handshake();
    logic [DK*DD-1:0] a, b;
    int t [3] = '{-1, -1, -1};
    int nv, lat, extra;
    a = rnd_msg();
    msg_d = a;
    start_d = 1'b1;
    nv = 0;
    for (int n = 0; n < 600 && nv < 3; n++) begin
      tick();
      if (valid_d) begin
        t[nv] = n;
        nv++;
        if (nv == 3) start_d = 1'b0;
      end
    end
    start_d = 1'b0;
    n_vec++; if (nv !== 3)          begin n_err++; $display("FAIL held_count: got %0d want 3", nv); end
    n_vec++; if (t[0] !== 155)      begin n_err++; $display("FAIL held_first: got %0d want 155", t[0]); end
    n_vec++; if (t[1] - t[0] !== 156) begin n_err++; $display("FAIL held_period1: got %0d want 156", t[1] - t[0]); end
    n_vec++; if (t[2] - t[1] !== 156) begin n_err++; $display("FAIL held_period2: got %0d want 156", t[2] - t[1]); end
    n_vec++; if (cw_d[DK*DD-1:0] !== a) begin n_err++; $display("FAIL held_sys: got %0h want %0h", cw_d[DK*DD-1:0], a); end
    tick();
    n_vec++; if (busy_d !== 1'b0)   begin n_err++; $display("FAIL held_release: got busy %b want 0", busy_d); end

    a = rnd_msg();
    b = ~a;
    go_d(a);
    for (int n = 0; n < 20; n++) tick();
    msg_d = b;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    wait_d(lat);
    n_vec++; if (lat !== 134)            begin n_err++; $display("FAIL busy_start_lat: got %0d want 134", lat); end
    n_vec++; if (cw_d[DK*DD-1:0] !== a)  begin n_err++; $display("FAIL latched_msg: got %0h want %0h", cw_d[DK*DD-1:0], a); end
    n_vec++; if (bad_rows(cw_d) !== 0)   begin n_err++; $display("FAIL latched_syndrome: got %0d bad rows want 0", bad_rows(cw_d)); end
    extra = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (valid_d) extra++;
    end
    n_vec++; if (extra !== 0)     begin n_err++; $display("FAIL busy_start_queued: got %0d extra valid want 0", extra); end
    n_vec++; if (busy_d !== 1'b0) begin n_err++; $display("FAIL busy_start_idle: got busy %b want 0", busy_d); end
  endtask

  task automatic test_reset_mid();
    logic [DK*DD-1:0] m;
    int extra, lat;
    go_d(rnd_msg());
    for (int n = 0; n < 50; n++) tick();
    rst = 1'b1;
    #1;
    n_vec++; if (busy_d !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy_d); end
    n_vec++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", valid_d); end
    n_vec++; if (cw_d !== '0)      begin n_err++; $display("FAIL mid_rst_cw_d: got %0h want 0", cw_d); end
    n_vec++; if (cw_s !== '0)      begin n_err++; $display("FAIL mid_rst_cw_s: got %0h want 0", cw_s); end
    tick();
    tick();
    rst = 1'b0;
    extra = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (valid_d) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL mid_rst_valid_after: got %0d want 0", extra); end
    m = rnd_msg();
    go_d(m);
    wait_d(lat);
    n_vec++; if (lat !== 155)           begin n_err++; $display("FAIL post_rst_lat: got %0d want 155", lat); end
    n_vec++; if (cw_d[DK*DD-1:0] !== m) begin n_err++; $display("FAIL post_rst_sys: got %0h want %0h", cw_d[DK*DD-1:0], m); end
    n_vec++; if (bad_rows(cw_d) !== 0)  begin n_err++; $display("FAIL post_rst_syndrome: got %0d bad rows want 0", bad_rows(cw_d)); end
  endtask

  initial begin
    set_default();
    set_small(0);
    test_reset();
    test_zero();
    test_small();
    test_code();
    test_handshake();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
